// File: rtl/adder_share_arbiter_if.sv
// Requester / datapath bus bundle for adder_share_arbiter.
// slave  : the arbiter side (consumes requests and the datapath result)
// master : the requesters plus datapath side
interface adder_share_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]            i_req;
   logic [NUM_REQ-1:0]            i_op;
   logic [NUM_REQ*DATA_WIDTH-1:0] i_opa;
   logic [NUM_REQ*DATA_WIDTH-1:0] i_opb;
   logic [DATA_WIDTH-1:0]         i_busr;
   logic [NUM_REQ-1:0]            o_gnt;
   logic [NUM_REQ-1:0]            o_done;
   logic [DATA_WIDTH-1:0]         o_result;
   logic [DATA_WIDTH-1:0]         o_busa;
   logic [DATA_WIDTH-1:0]         o_busb;
   logic                          o_op;
   logic                          o_is_busy;

   modport slave (
      input  i_req, i_op, i_opa, i_opb, i_busr,
      output o_gnt, o_done, o_result, o_busa, o_busb, o_op, o_is_busy
   );

   modport master (
      output i_req, i_op, i_opa, i_opb, i_busr,
      input  o_gnt, o_done, o_result, o_busa, o_busb, o_op, o_is_busy
   );
endinterface

// File: rtl/adder_share_arbiter.sv
// Shares one combinational adder datapath between NUM_REQ requesters.
// One transaction: grant a requester, freeze its operands on the datapath
// buses for EXEC_CYCLES, capture the result and pulse o_done for one cycle.
// Build option ADDER_SHARE_ARBITER_FIXED_PRIO_EN: lowest requesting index
// always wins; otherwise round-robin starting after the last winner.
//
// state | meaning
// IDLE  | waiting for any request; buses hold last transaction's values
// EXEC  | grant and buses frozen; counting down EXEC_CYCLES
// DONE  | result captured, o_done pulsing; grant released on exit
module adder_share_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int EXEC_CYCLES = 1
) (
   input logic                   ACLK,
   input logic                   ARST,
   adder_share_arbiter_if.slave  bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [NUM_REQ-1:0]     gnt_q, gnt_d;
   logic [NUM_REQ-1:0]     done_q, done_d;
   logic [DATA_WIDTH-1:0]  result_q, result_d;
   logic [DATA_WIDTH-1:0]  busa_q, busa_d;
   logic [DATA_WIDTH-1:0]  busb_q, busb_d;
   logic                   op_q, op_d;

   logic [IDX_W-1:0]       win_idx;
   logic [NUM_REQ-1:0]     win_oh;
   logic [DATA_WIDTH-1:0]  opa_arr [NUM_REQ];
   logic [DATA_WIDTH-1:0]  opb_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign opa_arr[g] = bus.i_opa[g*DATA_WIDTH +: DATA_WIDTH];
      assign opb_arr[g] = bus.i_opb[g*DATA_WIDTH +: DATA_WIDTH];
   end

`ifdef ADDER_SHARE_ARBITER_FIXED_PRIO_EN
   // Winner is the lowest requesting index (descending scan, last hit wins).
   always_comb begin
      win_idx = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (bus.i_req[i]) win_idx = IDX_W'(i);
      end
   end
`else
   logic [IDX_W-1:0] ptr_q, win_q;
   logic [IDX_W-1:0] hi_idx, lo_idx;
   logic             hi_found;

   // Round-robin: lowest requester above the last winner, else wrap to the lowest overall.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (bus.i_req[i]) begin
            lo_idx = IDX_W'(i);
            if (IDX_W'(i) > ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = IDX_W'(i);
            end
         end
      end
      win_idx = hi_found ? hi_idx : lo_idx;
   end

   // Remember the winner at grant; it becomes the priority pointer once the transaction ends.
   always_ff @(posedge ACLK or posedge ARST) begin
      if (ARST) begin
         ptr_q <= IDX_W'(NUM_REQ-1);
         win_q <= '0;
      end else begin
         if (state_q == IDLE && |bus.i_req) win_q <= win_idx;
         if (state_q == DONE) ptr_q <= win_q;
      end
   end
`endif

   assign win_oh = NUM_REQ'(1) << win_idx;

   // Next-state and datapath latch decisions.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      done_d   = done_q;
      result_d = result_q;
      busa_d   = busa_q;
      busb_d   = busb_q;
      op_d     = op_q;
      unique case (state_q)
         IDLE: begin
            if (|bus.i_req) begin
               gnt_d   = win_oh;
               busa_d  = opa_arr[win_idx];
               busb_d  = opb_arr[win_idx];
               op_d    = bus.i_op[win_idx];
               cnt_d   = CNT_W'(EXEC_CYCLES-1);
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               result_d = bus.i_busr;
               done_d   = gnt_q;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            done_d  = '0;
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset clears everything and aborts any transaction.
   always_ff @(posedge ACLK or posedge ARST) begin
      if (ARST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         result_q <= '0;
         busa_q   <= '0;
         busb_q   <= '0;
         op_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         result_q <= result_d;
         busa_q   <= busa_d;
         busb_q   <= busb_d;
         op_q     <= op_d;
      end
   end

   assign bus.o_gnt     = gnt_q;
   assign bus.o_done    = done_q;
   assign bus.o_result  = result_q;
   assign bus.o_busa    = busa_q;
   assign bus.o_busb    = busb_q;
   assign bus.o_op      = op_q;
   assign bus.o_is_busy = (state_q != IDLE);
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single combinational adder datapath between NUM_REQ independent requesters, such as the AXI-lite register front end, a DMA engine or a self-test engine.
- Sits between the requesters and the datapath.
- Per transaction it latches one requester's operands and op, drives the datapath buses, waits EXEC_CYCLES, captures the result and returns it with a one-cycle done pulse.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, operand/result width
EXEC_CYCLES, 1, cycles buses are held before result capture (1..15, allows multicycle path)

Ports:
ACLK  in  1  clock
ARST  in  1  asynchronous active-high reset
i_req  in  NUM_REQ  per-requester request level
i_op  in  NUM_REQ  per-requester op bit (bit k = requester k)
i_opa  in  NUM_REQ*DATA_WIDTH  operand A, slice k = requester k
i_opb  in  NUM_REQ*DATA_WIDTH  operand B, slice k = requester k
o_gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
o_done  out  NUM_REQ  one-cycle completion pulse to granted requester
o_result  out  DATA_WIDTH  captured datapath result, valid with o_done, held until next capture
o_busa  out  DATA_WIDTH  datapath operand A
o_busb  out  DATA_WIDTH  datapath operand B
o_op  out  1  datapath op select
i_busr  in  DATA_WIDTH  datapath result
o_is_busy  out  1  high in EXEC and DONE

Behaviour:
- Reset (async, ARST=1):
  - state=IDLE; all outputs 0.
  - Last-grant pointer = NUM_REQ-1, so requester 0 has top priority first.
  - Exec counter = 0.
  - Reset asserted mid-transaction aborts it; no o_done is issued.
- FSM states IDLE, EXEC, DONE:
  - IDLE:
    - If i_req != 0, select winner = first set bit searching ptr+1, ptr+2, ... with wrap modulo NUM_REQ.
    - Register o_gnt=onehot(winner), and latch o_busa/o_busb/o_op from the winner's slices.
    - counter=EXEC_CYCLES-1; go to EXEC.
    - If no request, stay in IDLE; buses keep their last values.
  - EXEC:
    - Buses and o_gnt are frozen; requester input changes are ignored.
    - If counter==0: o_result<=i_busr, o_done<=o_gnt, go to DONE. Otherwise decrement.
  - DONE:
    - o_done high for exactly this cycle; ptr<=winner.
    - o_gnt<=0; go to IDLE.
- Latency:
  - req sampled in IDLE at edge N → o_gnt high from N+1.
  - o_done/o_result valid at N+1+EXEC_CYCLES.
  - Back-to-back throughput: one transaction per EXEC_CYCLES+2 cycles.
- Request semantics:
  - Level-sensitive. A requester must drop i_req in the cycle it sees o_done.
  - A req still high in the IDLE cycle after DONE is treated as a new request.
  - i_req dropped during EXEC: the transaction still completes and o_done is still pulsed.
- Arithmetic: the arbiter never interprets data. o_result is i_busr bit-exact, with no width change or saturation; overflow wrap is the datapath's behaviour.
- Fairness:
  - With all NUM_REQ requesting continuously, grants rotate 0,1,...,NUM_REQ-1,0...
  - No requester waits more than NUM_REQ-1 transactions.
- Invariants: o_gnt and o_done are each one-hot or zero; o_done is a subset of the prior-cycle o_gnt.

Optional Feature:
ADDER_SHARE_ARBITER_FIXED_PRIO_EN
- Defined: fixed priority, lowest set index of i_req always wins. The pointer is not used or updated; starvation of high indices is permitted.
- Undefined (default): round-robin as described above.
- Timing and handshake are identical in both modes.

Test Plan:
- Reset, then i_req=0001, opa0=5, opb0=7, op0=0, bench datapath add, EXEC_CYCLES=1 → o_gnt=0001 at cycle 1, o_done=0001 with o_result=12 at cycle 2, o_gnt=0 at cycle 3.
- i_req=1111 held, each requester k given opa=k, opb=10 → grant sequence 0001,0010,0100,1000,0001; results 10,11,12,13; each o_done a single cycle; spacing 3 cycles.
- Wrap: after a requester-3 grant completes, i_req=1001 → requester 0 granted next; with FIXED_PRIO_EN, requester 0 granted every time while i_req=1001.
- Requester 1 drops i_req and changes opa in the first EXEC cycle (EXEC_CYCLES=3) → o_busa unchanged for 3 cycles; o_done=0010 still pulses.
- Overflow: opa=0xFFFFFFFF, opb=1, add → o_result=0x00000000; op=1 (sub) with 3−5 → 0xFFFFFFFE.
- ARST pulsed mid-EXEC → all outputs 0 immediately (async), no o_done; after release, i_req=0110 → requester 1 granted first.
